// File: rtl/fetch_pkg.sv
// ============================================================================
// Module : fetch_pkg
// Brief  : Shared types and constants for the instruction fetch queue.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fq_entry_t;

  function automatic int fq_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fq_storage.sv
// ============================================================================
// Module : fq_storage
// Brief  : DEPTH-entry register array holding {pc, inst}; one write, one read.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fq_storage
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = fq_ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [PW-1:0] wr_addr,
  input  fq_entry_t     wr_data,
  input  logic [PW-1:0] rd_addr,
  output fq_entry_t     rd_data
);

  // Data needs no reset: validity is tracked entirely by the parent's count.
  fq_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module : fetch_queue
// Brief  : Sequential instruction fetch with in-order queue to decode and
//          redirect flush. Optional same-cycle bypass: FETCH_QUEUE_BYPASS_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);

  localparam int            PW      = fq_ptr_w(DEPTH);
  localparam int            CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   pc_q;
  logic [31:0]   inflight_pc_q;
  logic          in_flight_q;
  logic          req_epoch_q;
  logic          epoch_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  logic          q_valid;
  logic          accept;
  logic          bypass;
  logic          push;
  logic          pop;
  logic [CW-1:0] occ;
  fq_entry_t     head;
  fq_entry_t     wr_entry;

  assign q_valid  = (count_q != '0);
  assign accept   = imem_rvalid && in_flight_q && (req_epoch_q == epoch_q) && !redirect_valid;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass   = accept && !q_valid;
`else
  assign bypass   = 1'b0;
`endif

  assign pop      = q_valid && id_ready;
  assign push     = accept && !(bypass && id_ready);
  assign wr_entry = '{pc: inflight_pc_q, inst: imem_rdata};

  // Occupancy after this cycle's pop, plus the slot reserved by the outstanding request.
  assign occ       = count_q - CW'(pop) + CW'(in_flight_q);
  assign imem_req  = reset && !redirect_valid && (occ < DEPTH_C);
  assign imem_addr = pc_q;

  always_comb begin
    id_valid = q_valid;
    id_inst  = q_valid ? head.inst : NOP_INST;
    id_pc    = q_valid ? head.pc   : 32'h0;
    if (bypass) begin
      id_valid = 1'b1;
      id_inst  = imem_rdata;
      id_pc    = inflight_pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      inflight_pc_q <= RESET_PC;
      in_flight_q   <= 1'b0;
      req_epoch_q   <= 1'b0;
      epoch_q       <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      in_flight_q <= imem_req;
      if (imem_req) begin
        inflight_pc_q <= pc_q;
        req_epoch_q   <= epoch_q;
        pc_q          <= pc_q + 32'd4;
      end
      if (redirect_valid) begin
        pc_q     <= redirect_pc & ~32'h3;
        epoch_q  <= ~epoch_q;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end

  fq_storage #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_storage (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr_q),
    .rd_data (head)
  );

`ifndef SYNTHESIS
  // A response with no outstanding request is dropped by the accept logic.
  a_rvalid_has_req : assert property (@(posedge clk) disable iff (!reset) imem_rvalid |-> in_flight_q);
`endif

endmodule

`default_nettype wire
